// File: rtl/multdiv_iterative.sv
// multdiv_iterative: multicycle signed multiply (shift-add) / divide (restoring), one bit per cycle.
module multdiv_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] a_mag, b_mag, hi, sa, sb, ma, mb, dsh;
  logic [WIDTH-1:0] lo, q;
  logic [WIDTH+1:0] msum, ddiff;
  logic [2*WIDTH-1:0] pm, ps;
  logic neg_a, neg_b, neg, is_div, start;
  // hi:lo is the product accumulator for multiply and the remainder:quotient pair for divide
  always_comb begin
    start = ctrl_MULT ^ ctrl_DIV;
    sa = {data_operandA[WIDTH-1], data_operandA};
    sb = {data_operandB[WIDTH-1], data_operandB};
    ma = sa[WIDTH] ? -sa : sa;
    mb = sb[WIDTH] ? -sb : sb;
    neg = neg_a ^ neg_b;
    msum = {1'b0, hi} + (lo[0] ? {1'b0, a_mag} : '0);
    dsh = {hi[WIDTH-1:0], lo[WIDTH-1]};
    ddiff = {1'b0, dsh} - {1'b0, b_mag};
    pm = {hi[WIDTH-1:0], lo};
    ps = neg ? -pm : pm;
    q = neg ? -lo : lo;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      data_result <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        state <= ctrl_DIV ? DIV : MUL;
        is_div <= ctrl_DIV;
        cnt <= '0;
        busy <= 1'b1;
        neg_a <= data_operandA[WIDTH-1];
        neg_b <= data_operandB[WIDTH-1];
        a_mag <= ma;
        b_mag <= mb;
        hi <= '0;
        lo <= ctrl_DIV ? ma[WIDTH-1:0] : mb[WIDTH-1:0];
      end else if (state == MUL || state == DIV) begin
        cnt <= cnt + CW'(1);
        if (state == MUL) begin
          hi <= msum[WIDTH+1:1];
          lo <= {msum[0], lo[WIDTH-1:1]};
        end else begin
          hi <= ddiff[WIDTH+1] ? dsh : ddiff[WIDTH:0];
          lo <= {lo[WIDTH-2:0], ~ddiff[WIDTH+1]};
        end
        if (cnt == LAST) begin
          state <= DONE;
          busy <= 1'b0;
        end
      end else if (state == DONE) begin
        state <= IDLE;
        data_resultRDY <= 1'b1;
        data_result <= !is_div ? ps[WIDTH-1:0] : (b_mag == '0 ? '0 : q);
        // a positive quotient of magnitude 2^(WIDTH-1) only arises from MIN / -1
        data_exception <= !is_div ? !(&ps[2*WIDTH-1:WIDTH-1] || ~|ps[2*WIDTH-1:WIDTH-1])
                                  : (b_mag == '0 || (!neg && lo[WIDTH-1]));
      end
    end
  end
endmodule

// File: tb/tb_multdiv_iterative.sv
// tb_multdiv_iterative: random + directed stimulus checked every cycle against an arithmetic model.
module tb_multdiv_iterative;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [W-1:0] data_operandA = '0, data_operandB = '0, data_result;
  logic ctrl_MULT = 1'b0, ctrl_DIV = 1'b0, data_exception, data_resultRDY, busy;
  int vectors = 0, errors = 0;
  int cyc = 0, due = 0;
  logic pend = 1'b0, exp_rdy = 1'b0, exp_busy = 1'b0, exp_exc = 1'b0, p_exc = 1'b0;
  logic [W-1:0] exp_res = '0, p_res = '0;

  always #5 clk = ~clk;

  multdiv_iterative #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .data_result(data_result),
    .data_exception(data_exception), .data_resultRDY(data_resultRDY), .busy(busy)
  );

  function automatic logic [W:0] ref_op(input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    logic [W-1:0] lo;
    if (!d) begin
      p = longint'($signed(a)) * longint'($signed(b));
      lo = p[W-1:0];
      return {p != longint'($signed(lo)), lo};
    end
    if (b == '0) return {1'b1, {W{1'b0}}};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b1, a};
    p = longint'($signed(a)) / longint'($signed(b));
    return {1'b0, p[W-1:0]};
  endfunction

  // model: a start at edge k delivers its result at edge k+W+1 unless reset or a new start intervenes
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      pend <= 1'b0;
      exp_rdy <= 1'b0;
      exp_busy <= 1'b0;
      exp_res <= '0;
      exp_exc <= 1'b0;
    end else if (ctrl_MULT ^ ctrl_DIV) begin
      {p_exc, p_res} <= ref_op(ctrl_DIV, data_operandA, data_operandB);
      pend <= 1'b1;
      due <= cyc + 1 + W + 1;
      exp_rdy <= 1'b0;
      exp_busy <= 1'b1;
    end else begin
      exp_rdy <= pend && (cyc + 1 == due);
      exp_busy <= pend && (cyc + 1 <= due - 2);
      if (pend && cyc + 1 == due) begin
        exp_res <= p_res;
        exp_exc <= p_exc;
        pend <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    check("rdy", {{W{1'b0}}, data_resultRDY}, {{W{1'b0}}, exp_rdy});
    check("busy", {{W{1'b0}}, busy}, {{W{1'b0}}, exp_busy});
    check("result", {1'b0, data_result}, {1'b0, exp_res});
    check("exception", {{W{1'b0}}, data_exception}, {{W{1'b0}}, exp_exc});
  end

  task automatic go(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = m;
    ctrl_DIV = d;
    @(negedge clk);
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic drain();
    repeat (W + 3) @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'd1;
      4: return W'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("model_mul_7x-6", ref_op(1'b0, 32'd7, -32'd6), {1'b0, 32'hFFFFFFD6});
    check("model_mul_ovf", ref_op(1'b0, 32'h00010000, 32'h00010000), {1'b1, 32'h0});
    check("model_mul_min", ref_op(1'b0, 32'h80000000, 32'd1), {1'b0, 32'h80000000});
    check("model_div_-100/7", ref_op(1'b1, -32'd100, 32'd7), {1'b0, 32'hFFFFFFF2});
    check("model_div_by0", ref_op(1'b1, 32'd5, 32'd0), {1'b1, 32'h0});
    check("model_div_min/-1", ref_op(1'b1, 32'h80000000, 32'hFFFFFFFF), {1'b1, 32'h80000000});
    go(1'b1, 1'b0, 32'd7, -32'd6);
    n = 0;
    while (!data_resultRDY && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("latency", W'(n), W'(W + 1));
    check("mul_7x-6", {data_exception, data_result}, {1'b0, 32'hFFFFFFD6});
    drain();
    go(1'b1, 1'b0, 32'h00010000, 32'h00010000); drain();
    check("mul_ovf", {data_exception, data_result}, {1'b1, 32'h0});
    go(1'b1, 1'b0, 32'h80000000, 32'd1); drain();
    go(1'b0, 1'b1, -32'd100, 32'd7); drain();
    check("div_-100/7", {data_exception, data_result}, {1'b0, 32'hFFFFFFF2});
    go(1'b0, 1'b1, 32'd100, -32'd7); drain();
    go(1'b0, 1'b1, 32'd6, 32'd7); drain();
    check("div_6/7", {data_exception, data_result}, {1'b0, 32'h0});
    go(1'b0, 1'b1, 32'd5, 32'd0); drain();
    go(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF); drain();
    check("div_min/-1", {data_exception, data_result}, {1'b1, 32'h80000000});
    go(1'b1, 1'b0, 32'd3, 32'd3);
    repeat (9) @(negedge clk);
    go(1'b0, 1'b1, 32'd9, 32'd2); drain();
    check("abort_div", {data_exception, data_result}, {1'b0, 32'd4});
    go(1'b0, 1'b1, 32'd1000, 32'd3);
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drain();
    check("reset_abort", {busy, data_exception, data_result}, '0);
    go(1'b1, 1'b1, 32'd4, 32'd5); drain();
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) == 1) go(1'b1, 1'b0, pick(), pick());
      else go(1'b0, 1'b1, pick(), pick());
      repeat ($urandom_range(0, 40)) @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/multdiv_iterative.md
Name: multdiv_iterative

Overview:
- Multicycle signed integer multiply/divide unit in the processor execute stage.
- Consumes operand values read out of the falling-edge register file.
- Produces a result, a one-cycle ready strobe and an exception flag; the write-back path writes these into the register file.
- One shift/add (multiply) or shift/subtract (divide) iteration per rising clk edge; no combinational array multiplier.

Parameters:
- WIDTH, 32, operand and result width in bits (two's complement, WIDTH >= 4).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_operandA  input  WIDTH  multiplicand / dividend; sampled only on the start edge.
- data_operandB  input  WIDTH  multiplier / divisor; sampled only on the start edge.
- ctrl_MULT  input  1  one-cycle start pulse for multiply.
- ctrl_DIV  input  1  one-cycle start pulse for divide.
- data_result  output  WIDTH  low WIDTH bits of the product, or the quotient.
- data_exception  output  1  overflow or divide-by-zero; valid while data_resultRDY is high.
- data_resultRDY  output  1  single-cycle strobe: result valid.
- busy  output  1  high while an operation is in flight.

Behaviour:
- Reset is synchronous: at a rising edge with reset=1, state=IDLE, iteration counter=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0. Reset overrides any start sampled on the same edge. Reset mid-operation aborts the operation with no RDY strobe.
- FSM states: IDLE, MUL, DIV, DONE.
- Start condition: exactly one of ctrl_MULT/ctrl_DIV is high at a rising edge, in any state.
  - Latch both operands and their signs, clear the counter, go to MUL or DIV.
  - Both controls high at once: ignored; state unchanged.
- A start while busy aborts the current operation and restarts with the new operands. The aborted operation never raises RDY.
- MUL: unsigned shift-add on the operand magnitudes, one bit per cycle, WIDTH cycles, producing a 2*WIDTH magnitude product. Then go to DONE.
- DIV: restoring division on the magnitudes, one quotient bit per cycle, WIDTH cycles. Then go to DONE.
- DONE (one cycle): apply the sign correction, register the outputs, assert data_resultRDY=1, return to IDLE. busy=0 during DONE.
- Latency: the start edge is edge 0. The outputs update at edge WIDTH+1, so data_resultRDY is high for exactly one cycle starting WIDTH+1 cycles after the start (33 cycles for WIDTH=32).
- Multiply result:
  - Sign = signA XOR signB; the product is negated if the sign is negative.
  - data_result = low WIDTH bits.
  - data_exception=1 iff the signed 2*WIDTH product is not representable in WIDTH bits, i.e. the upper WIDTH+1 bits are not all equal.
- Divide result:
  - Quotient is truncated toward zero; the remainder is discarded.
  - Divisor 0: data_result=0, data_exception=1, same latency.
  - Most-negative / -1: data_result = most-negative value (wrapped), data_exception=1.
  - All other cases: data_exception=0.
- Most-negative operands: magnitudes are held in WIDTH+1 bits internally so the magnitude 2^(WIDTH-1) is exact.
- Output holding: data_result and data_exception hold their DONE values until the next DONE or reset. data_resultRDY is 0 outside DONE.
- busy is 1 in MUL and DIV, 0 in IDLE and DONE.
- Operand inputs are don't-care except on the start edge.

Test Plan:
- Reset, then ctrl_MULT pulse with A=7, B=-6 -> RDY exactly 33 cycles later; result=0xFFFFFFD6 (-42), exception=0; busy high for 32 cycles.
- ctrl_MULT with A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1. Repeat with A=0x80000000, B=1 -> result=0x80000000, exception=0.
- ctrl_DIV with A=-100, B=7 -> result=0xFFFFFFF2 (-14), exception=0. Then A=100, B=-7 -> -14. Then A=6, B=7 -> 0.
- ctrl_DIV with A=5, B=0 -> result=0, exception=1 at cycle 33. Then A=0x80000000, B=-1 -> result=0x80000000, exception=1.
- ctrl_MULT with A=3, B=3; ctrl_DIV with A=9, B=2 issued 10 cycles later -> single RDY 33 cycles after the second start, result=4; no RDY for the aborted multiply.
- Start a divide, assert reset at cycle 15 for 1 cycle -> all outputs 0, busy=0, no RDY ever. Both controls high together -> busy stays 0, no RDY.
